// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// State encoding and the bit-reversed mux4to1 select mapping.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      GAP
   } arb_state_t;

   // The mux4to1 select lines are wired in reverse bit order.
   function automatic logic [1:0] idx2sel(logic [1:0] i);
      return {i[0], i[1]};
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotating-priority picker: first set request after 'last',
// scanning (last+1)..(last+4) with wrap, so 'last' itself has lowest priority.
module rr_pick (
   input  logic [3:0] req,
   input  logic [1:0] last,
   output logic [1:0] pick,
   output logic       any
);

   logic [1:0] idx;

   always_comb begin
      pick = last;
      any  = 1'b0;
      idx  = last;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (req[idx] && !any) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one mux4to1 between four requesters, with
// bounded grant length, a fixed idle gap between grants and a timeout pulse.
module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX   = 100,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic       hz100,
   input  logic       reset,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       valid,
   output logic [1:0] owner,
   output logic [1:0] sel,
   output logic       timeout
);

   localparam int unsigned HW = $clog2(HOLD_MAX + 1);
   localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

   arb_state_t    state, state_d;
   logic [HW-1:0] hold_cnt, hold_d;
   logic [GW-1:0] gap_cnt, gap_d;
   logic [1:0]    last, last_d;
   logic [3:0]    gnt_d;
   logic [1:0]    owner_d;
   logic          timeout_d;
   logic [1:0]    pick;
   logic          any;

   rr_pick u_pick (
      .req  (req),
      .last (last),
      .pick (pick),
      .any  (any)
   );

   always_comb begin
      state_d   = state;
      hold_d    = hold_cnt;
      gap_d     = gap_cnt;
      last_d    = last;
      gnt_d     = gnt;
      owner_d   = owner;
      timeout_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << pick;
               owner_d = pick;
               hold_d  = '0;
            end
         end
         GRANT: begin
            hold_d = hold_cnt + 1'b1;
            // Voluntary release is tested first so it wins over a timeout.
            if (!req[owner]) begin
               state_d = GAP;
               gnt_d   = '0;
               last_d  = owner;
               gap_d   = '0;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d   = GAP;
               gnt_d     = '0;
               last_d    = owner;
               gap_d     = '0;
               timeout_d = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge hz100) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         last     <= 2'd3;
         gnt      <= '0;
         owner    <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_d;
         hold_cnt <= hold_d;
         gap_cnt  <= gap_d;
         last     <= last_d;
         gnt      <= gnt_d;
         owner    <= owner_d;
         timeout  <= timeout_d;
      end
   end

   assign valid = |gnt;
   assign sel   = idx2sel(owner);

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter with HOLD_MAX=4, GAP_CYCLES=1;
// expected values are hand-computed from the arbitration rules.
module tb_rr_mux_arbiter;

   logic       hz100 = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       valid;
   logic [1:0] owner;
   logic [1:0] sel;
   logic       timeout;

   int n_checks = 0;
   int n_errors = 0;

   logic [1:0] sel_exp [4];

   rr_mux_arbiter #(
      .HOLD_MAX   (4),
      .GAP_CYCLES (1)
   ) dut (
      .hz100   (hz100),
      .reset   (reset),
      .req     (req),
      .gnt     (gnt),
      .valid   (valid),
      .owner   (owner),
      .sel     (sel),
      .timeout (timeout)
   );

   always #5 hz100 = ~hz100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge hz100);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic check_grant(input string tag, input logic [1:0] o);
      check({tag, " gnt"},   32'(gnt),   32'(4'b0001 << o));
      check({tag, " owner"}, 32'(owner), 32'(o));
      check({tag, " sel"},   32'(sel),   32'(sel_exp[o]));
      check({tag, " valid"}, 32'(valid), 32'd1);
   endtask

   initial begin
      sel_exp[0] = 2'b00;
      sel_exp[1] = 2'b10;
      sel_exp[2] = 2'b01;
      sel_exp[3] = 2'b11;
      reset = 1'b1;
      req   = 4'b0000;
      step();
      step();
      check("rst gnt",     32'(gnt),     32'd0);
      check("rst valid",   32'(valid),   32'd0);
      check("rst owner",   32'(owner),   32'd0);
      check("rst sel",     32'(sel),     32'd0);
      check("rst timeout", 32'(timeout), 32'd0);
      reset = 1'b0;

      // single request: one edge of latency
      req = 4'b0001;
      step();
      check_grant("t1", 2'd0);
      req = 4'b0000;
      step();
      check("t1 rel gnt",     32'(gnt),     32'd0);
      check("t1 rel timeout", 32'(timeout), 32'd0);
      step();

      // continuous requests: forced rotation 0,1,2,3,0 with 6-cycle period
      do_reset();
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            check_grant($sformatf("t2 k%0d c%0d", k, c), 2'(k % 4));
         end
         step();
         check($sformatf("t2 k%0d gap gnt", k),  32'(gnt),     32'd0);
         check($sformatf("t2 k%0d gap to", k),   32'(timeout), 32'd1);
         check($sformatf("t2 k%0d gap sel", k),  32'(sel),     32'(sel_exp[k % 4]));
         step();
         check($sformatf("t2 k%0d idle gnt", k), 32'(gnt),     32'd0);
         check($sformatf("t2 k%0d idle to", k),  32'(timeout), 32'd0);
      end

      // voluntary release after 3 grant cycles
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step();
         check_grant($sformatf("t4 c%0d", c), 2'd2);
      end
      req = 4'b0000;
      step();
      check("t4 rel gnt",   32'(gnt),     32'd0);
      check("t4 rel valid", 32'(valid),   32'd0);
      check("t4 rel to",    32'(timeout), 32'd0);
      check("t4 rel owner", 32'(owner),   32'd2);
      check("t4 rel sel",   32'(sel),     32'(2'b01));
      step();
      req = 4'b1111;
      step();
      check_grant("t4 last2", 2'd3);
      req = 4'b0000;
      step();
      step();

      // wrap: 0 first after reset, then 3 after 0 times out
      do_reset();
      req = 4'b1001;
      for (int c = 0; c < 4; c++) begin
         step();
         check_grant($sformatf("t5 c%0d", c), 2'd0);
      end
      step();
      check("t5 to", 32'(timeout), 32'd1);
      step();
      step();
      check_grant("t5 wrap", 2'd3);
      for (int c = 0; c < 3; c++) begin
         step();
         check_grant($sformatf("t5b c%0d", c), 2'd3);
      end
      // drop on the final hold cycle: voluntary release, no timeout
      req = 4'b0001;
      step();
      check("t5 both gnt", 32'(gnt),     32'd0);
      check("t5 both to",  32'(timeout), 32'd0);
      req = 4'b0000;
      step();

      // reset on the cycle that would otherwise force a timeout
      do_reset();
      req = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         step();
         check_grant($sformatf("t6 c%0d", c), 2'd1);
      end
      reset = 1'b1;
      step();
      check("t6 rst gnt",   32'(gnt),     32'd0);
      check("t6 rst valid", 32'(valid),   32'd0);
      check("t6 rst sel",   32'(sel),     32'd0);
      check("t6 rst owner", 32'(owner),   32'd0);
      check("t6 rst to",    32'(timeout), 32'd0);
      reset = 1'b0;
      req   = 4'b1000;
      step();
      check_grant("t6 post", 2'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
